// File: rtl/sub_pkg.sv
// Shared types and default sizing for the subtractor result checker.
package sub_pkg;

    localparam int unsigned DEF_WIDTH   = 4;
    localparam int unsigned DEF_LATENCY = 1;
    localparam int unsigned DEF_CNT_W   = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/sub_delay_line.sv
// Fixed-depth valid/data shift pipe; data of invalid slots is held at zero.
module sub_delay_line #(
    parameter int unsigned DEPTH  = 1,
    parameter int unsigned DATA_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              validIn,
    input  logic [DATA_W-1:0] dataIn,
    output logic              validOut,
    output logic [DATA_W-1:0] dataOut
);

    logic [DEPTH-1:0]  v_q;
    logic [DATA_W-1:0] d_q [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            v_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_q[i] <= '0;
            end
        end else begin
            v_q[0] <= validIn;
            d_q[0] <= validIn ? dataIn : '0;
            for (int i = 1; i < DEPTH; i++) begin
                v_q[i] <= v_q[i-1];
                d_q[i] <= d_q[i-1];
            end
        end
    end

    assign validOut = v_q[DEPTH-1];
    assign dataOut  = d_q[DEPTH-1];

endmodule

// File: rtl/sub_checker.sv
// Checks an external subtractor against zero-extended a-b, LATENCY cycles later.
// Define SUB_CHECKER_DISPLAY_EN to print a message on every mismatch.
module sub_checker
    import sub_pkg::*;
#(
    parameter int unsigned WIDTH   = DEF_WIDTH,
    parameter int unsigned LATENCY = DEF_LATENCY,
    parameter int unsigned CNT_W   = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    validIn,
    input  logic [WIDTH-1:0]        aIn,
    input  logic [WIDTH-1:0]        bIn,
    input  logic signed [WIDTH:0]   subOut,
    output logic signed [WIDTH:0]   expOut,
    output logic                    mismatch,
    output logic                    errFlag,
    output logic                    busy,
    output logic                    done,
    output logic [CNT_W-1:0]        errCnt,
    output logic [CNT_W-1:0]        checkCnt
);

    localparam int unsigned RES_W = WIDTH + 1;
    localparam int unsigned DRN_W = $clog2(LATENCY + 1);

    state_t             state;
    logic [DRN_W-1:0]   drain_cnt;

    logic               start_go_c;
    logic               push_c;
    logic [RES_W-1:0]   exp_c;
    logic               pipe_rst_c;
    logic               tail_v;
    logic [RES_W-1:0]   tail_d;
    logic               cmp_c;
    logic               diff_c;

    // A start is only honoured from IDLE or DONE; it also flushes the pipe.
    assign start_go_c = start && (state == ST_IDLE || state == ST_DONE);
    assign push_c     = validIn && (state == ST_RUN);
    assign exp_c      = {1'b0, aIn} - {1'b0, bIn};
    assign pipe_rst_c = rst | start_go_c;

    sub_delay_line #(
        .DEPTH  (LATENCY),
        .DATA_W (RES_W)
    ) u_pipe (
        .clk      (clk),
        .rst      (pipe_rst_c),
        .validIn  (push_c),
        .dataIn   (exp_c),
        .validOut (tail_v),
        .dataOut  (tail_d)
    );

    // Tail slot is zero whenever it is invalid, so it can drive expOut directly.
    assign expOut = $signed(tail_d);
    assign cmp_c  = tail_v && (state == ST_RUN || state == ST_DRAIN);
    assign diff_c = cmp_c && (subOut != $signed(tail_d));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            drain_cnt <= '0;
            mismatch  <= 1'b0;
            errFlag   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            errCnt    <= '0;
            checkCnt  <= '0;
        end else begin
            mismatch <= diff_c;

            if (start_go_c) begin
                errCnt   <= '0;
                checkCnt <= '0;
                errFlag  <= 1'b0;
            end else if (cmp_c) begin
                if (checkCnt != '1) begin
                    checkCnt <= checkCnt + CNT_W'(1);
                end
                if (diff_c) begin
                    errFlag <= 1'b1;
                    if (errCnt != '1) begin
                        errCnt <= errCnt + CNT_W'(1);
                    end
                end
            end

`ifdef SUB_CHECKER_DISPLAY_EN
            if (diff_c) begin
                $display("test failed(subOut!=answer): %0d != %0d", subOut, $signed(tail_d));
            end
`endif

            // Stop has priority over start while running.
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                        done  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DRN_W'(1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == DRN_W'(LATENCY)) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sub_checker.sv
// Directed bench for sub_checker: default config plus a CNT_W=2 saturation instance.
module tb_sub_checker;

    logic              clk = 1'b0;
    logic              rst, start, stop, validIn;
    logic [3:0]        aIn, bIn;
    logic signed [4:0] subOut;
    logic signed [4:0] expOut;
    logic              mismatch, errFlag, busy, done;
    logic [7:0]        errCnt, checkCnt;

    logic              rst_b, start_b, stop_b, validIn_b;
    logic [3:0]        aIn_b, bIn_b;
    logic signed [4:0] subOut_b;
    logic signed [4:0] expOut_b;
    logic              mismatch_b, errFlag_b, busy_b, done_b;
    logic [1:0]        errCnt_b, checkCnt_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sub_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .validIn(validIn),
        .aIn(aIn), .bIn(bIn), .subOut(subOut), .expOut(expOut),
        .mismatch(mismatch), .errFlag(errFlag), .busy(busy), .done(done),
        .errCnt(errCnt), .checkCnt(checkCnt)
    );

    sub_checker #(.WIDTH(4), .LATENCY(1), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst_b), .start(start_b), .stop(stop_b), .validIn(validIn_b),
        .aIn(aIn_b), .bIn(bIn_b), .subOut(subOut_b), .expOut(expOut_b),
        .mismatch(mismatch_b), .errFlag(errFlag_b), .busy(busy_b), .done(done_b),
        .errCnt(errCnt_b), .checkCnt(checkCnt_b)
    );

    task automatic check(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_exp"},  int'(expOut), 0);
        check({tag, "_mis"},  int'(mismatch), 0);
        check({tag, "_flag"}, int'(errFlag), 0);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_err"},  int'(errCnt), 0);
        check({tag, "_chk"},  int'(checkCnt), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; stop = 1'b0; validIn = 1'b0;
        aIn = '0; bIn = '0; subOut = '0;
        rst_b = 1'b1; start_b = 1'b0; stop_b = 1'b0; validIn_b = 1'b0;
        aIn_b = '0; bIn_b = '0; subOut_b = '0;
        step(); step();
        check_all_zero("reset");
        rst = 1'b0; rst_b = 1'b0;

        // Start a run
        start = 1'b1; step(); start = 1'b0;
        check("run_busy", int'(busy), 1);
        check("run_done", int'(done), 0);

        // 9-3
        validIn = 1'b1; aIn = 4'd9; bIn = 4'd3; step();
        check("e9m3_exp", int'(expOut), 6);
        subOut = 5'sd6; aIn = 4'd0; bIn = 4'd15; step();
        check("e9m3_mis", int'(mismatch), 0);
        check("e9m3_chk", int'(checkCnt), 1);
        check("e0m15_exp", int'(expOut), -15);

        subOut = 5'(-15); aIn = 4'd15; bIn = 4'd0; step();
        check("e0m15_mis", int'(mismatch), 0);
        check("e0m15_chk", int'(checkCnt), 2);
        check("e15m0_exp", int'(expOut), 15);

        subOut = 5'sd15; aIn = 4'd5; bIn = 4'd7; step();
        check("e15m0_mis", int'(mismatch), 0);
        check("e5m7_exp", int'(expOut), -2);

        // Faulty subtractor result: 3 instead of -2
        subOut = 5'sd3; aIn = 4'd2; bIn = 4'd1; step();
        check("bad_mis", int'(mismatch), 1);
        check("bad_err", int'(errCnt), 1);
        check("bad_flag", int'(errFlag), 1);
        check("bad_chk", int'(checkCnt), 4);

        subOut = 5'sd1; validIn = 1'b0; step();
        check("after_mis", int'(mismatch), 0);
        check("after_flag", int'(errFlag), 1);
        check("after_err", int'(errCnt), 1);
        check("after_chk", int'(checkCnt), 5);
        check("after_exp", int'(expOut), 0);

        // Stop with an entry pushed on the stop edge
        validIn = 1'b1; aIn = 4'd4; bIn = 4'd6; stop = 1'b1; step();
        check("drain_busy", int'(busy), 1);
        check("drain_done", int'(done), 0);
        check("drain_exp", int'(expOut), -2);
        stop = 1'b0; subOut = 5'(-2); aIn = 4'd1; bIn = 4'd1; step();
        check("donest_chk", int'(checkCnt), 6);
        check("donest_err", int'(errCnt), 1);
        check("donest_done", int'(done), 1);
        check("donest_busy", int'(busy), 0);
        check("donest_mis", int'(mismatch), 0);
        validIn = 1'b0; step();
        check("done_noexp", int'(expOut), 0);
        check("done_hold", int'(checkCnt), 6);
        check("done_flag", int'(errFlag), 1);

        // Restart from DONE clears the run statistics
        start = 1'b1; step(); start = 1'b0;
        check("rst2_chk", int'(checkCnt), 0);
        check("rst2_err", int'(errCnt), 0);
        check("rst2_flag", int'(errFlag), 0);
        check("rst2_busy", int'(busy), 1);
        check("rst2_done", int'(done), 0);

        // Reset with an entry in flight
        validIn = 1'b1; aIn = 4'd7; bIn = 4'd2; subOut = 5'sd0; step();
        check("inflt_exp", int'(expOut), 5);
        rst = 1'b1; validIn = 1'b0; step();
        rst = 1'b0;
        check_all_zero("midrst");
        validIn = 1'b1; aIn = 4'd3; bIn = 4'd1; stop = 1'b1; step();
        check("idle_exp", int'(expOut), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_done", int'(done), 0);
        validIn = 1'b0; stop = 1'b0; step();
        check("idle_mis", int'(mismatch), 0);
        check("idle_chk", int'(checkCnt), 0);

        // Start and stop together while running: stop wins
        start = 1'b1; step();
        stop = 1'b1; step();
        start = 1'b0; stop = 1'b0;
        check("ss_busy", int'(busy), 1);
        check("ss_done", int'(done), 0);
        step();
        check("ss_done2", int'(done), 1);
        check("ss_busy2", int'(busy), 0);

        // Saturation with CNT_W=2: five wrong results
        start_b = 1'b1; step(); start_b = 1'b0;
        validIn_b = 1'b1; aIn_b = 4'd1; bIn_b = 4'd0; subOut_b = 5'sd0;
        step();
        step(); step(); step();
        check("sat3_err", int'(errCnt_b), 3);
        check("sat3_chk", int'(checkCnt_b), 3);
        step(); step();
        validIn_b = 1'b0;
        check("sat5_err", int'(errCnt_b), 3);
        check("sat5_chk", int'(checkCnt_b), 3);
        check("sat5_flag", int'(errFlag_b), 1);
        check("sat5_mis", int'(mismatch_b), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
